// File: rtl/imm_pkg.sv
// Shared types for the decode stage: immediate-select codes, RV32I opcodes and the decoded entry.
// With DEC_ILLEGAL_CHK_EN defined, the entry also carries an illegal-opcode flag.
package imm_pkg;

    localparam int unsigned DEC_XLEN = 32;
    localparam int unsigned DEC_PC_W = 32;

    typedef enum logic [2:0] {
        SEL_NONE = 3'b000,
        SEL_IZ   = 3'b001,
        SEL_I    = 3'b010,
        SEL_S    = 3'b011,
        SEL_B    = 3'b100,
        SEL_U    = 3'b101,
        SEL_J    = 3'b110
    } imm_sel_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [DEC_PC_W-1:0] pc;
        logic [DEC_XLEN-1:0] instr;
        logic [DEC_XLEN-1:0] imm;
        imm_sel_e            sel;
`ifdef DEC_ILLEGAL_CHK_EN
        logic                illegal;
`endif
    } dec_entry_t;

endpackage

// File: rtl/imm_decode_stage_extend.sv
// Immediate generator (module extend): builds the 32-bit immediate selected by sel
// from the instruction's upper bits.
module extend
    import imm_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_sel_e    sel,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (sel)
            SEL_IZ: imm = {20'b0, instr[31:20]};
            SEL_I:  imm = {{20{instr[31]}}, instr[31:20]};
            SEL_S:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            SEL_B:  imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            SEL_U:  imm = {instr[31:12], 12'b0};
            SEL_J:  imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode stage: classifies fetched instructions, extends the immediate and holds entries in a
// main register plus one skid slot. Optional out_illegal port with DEC_ILLEGAL_CHK_EN.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = DEC_XLEN,
    parameter int unsigned PC_W = DEC_PC_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_sel
`ifdef DEC_ILLEGAL_CHK_EN
    ,
    output logic            out_illegal
`endif
);

    function automatic imm_sel_e decode_sel(input logic [31:0] instr);
        imm_sel_e s;
        case (instr[6:0])
            OPC_LOAD, OPC_JALR: s = SEL_I;
            OPC_OPIMM:          s = (instr[13:12] == 2'b01) ? SEL_IZ : SEL_I;
            OPC_STORE:          s = SEL_S;
            OPC_BRANCH:         s = SEL_B;
            OPC_LUI, OPC_AUIPC: s = SEL_U;
            OPC_JAL:            s = SEL_J;
            default:            s = SEL_NONE;
        endcase
        return s;
    endfunction

`ifdef DEC_ILLEGAL_CHK_EN
    function automatic logic decode_illegal(input logic [6:0] opc);
        logic ill;
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OPIMM,
            OPC_OP, OPC_LUI, OPC_AUIPC, OPC_MISC, OPC_SYSTEM: ill = 1'b0;
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction
`endif

    dec_entry_t  main_q;
    dec_entry_t  skid_q;
    dec_entry_t  in_entry;
    imm_sel_e    in_sel;
    logic [31:0] in_imm;
    logic        out_valid_q;
    logic        skid_valid_q;
    logic        in_ready_q;
    logic        accept;

    assign in_sel = decode_sel(in_instr);

    extend u_extend (
        .instr (in_instr[31:7]),
        .sel   (in_sel),
        .imm   (in_imm)
    );

    always_comb begin
        in_entry       = '0;
        in_entry.pc    = in_pc;
        in_entry.instr = in_instr;
        in_entry.imm   = in_imm;
        in_entry.sel   = in_sel;
`ifdef DEC_ILLEGAL_CHK_EN
        in_entry.illegal = decode_illegal(in_instr[6:0]);
`endif
    end

    assign accept = in_valid & in_ready_q;

    // in_ready is registered from the next skid state, so it always equals !skid_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_q       <= skid_q;
                out_valid_q  <= 1'b1;
                if (accept) begin
                    skid_q <= in_entry;
                end
                skid_valid_q <= accept;
                in_ready_q   <= !accept;
            end else begin
                if (accept) begin
                    main_q <= in_entry;
                end
                out_valid_q  <= accept;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end
        end else if (accept) begin
            skid_q       <= in_entry;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = main_q.instr;
    assign out_pc    = main_q.pc;
    assign out_imm   = main_q.imm;
    assign out_sel   = main_q.sel;
`ifdef DEC_ILLEGAL_CHK_EN
    assign out_illegal = main_q.illegal;
`endif

endmodule
